// File: rtl/note_div_calc.sv
// ============================================================================
// Module   : note_div_calc
// Purpose  : Sequential CLK_FREQ/freq divider producing the note_gen clock
//            divider, with octave shift, SILENCE mapping and saturation.
//            Optional macro ROUND_DIV_EN selects round-to-nearest division.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module note_div_calc #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SILENCE  = 100_000_000,
    parameter int OUT_W    = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      freq_in,
    input  logic [2:0]       octave,
    output logic [OUT_W-1:0] note_div,
    output logic             busy,
    output logic             done
);

    localparam int DVD_W = 28;
    localparam int DSR_W = 33;
    localparam logic [DVD_W-1:0] c_CLK     = DVD_W'(CLK_FREQ);
    localparam logic [31:0]      c_SILENCE = 32'(SILENCE);
    localparam logic [OUT_W-1:0] c_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_f;
    logic [2:0]        r_o;
    logic              r_primed;
    logic [DSR_W-1:0]  r_dsr;
    logic [DVD_W-1:0]  r_dvd;
    logic [DSR_W-1:0]  r_rem;
    logic [DVD_W-1:0]  r_quo;
    logic [4:0]        r_cnt;

    logic              w_start;
    logic [DSR_W-1:0]  w_dsr_prep;
    logic [DVD_W-1:0]  w_dvd_prep;
    logic [DSR_W:0]    w_rem_sh;
    logic              w_ge;
    logic [OUT_W-1:0]  w_res;

    assign w_start = !r_primed || ({freq_in, octave} != {r_f, r_o});

    always_comb begin
        w_dsr_prep = {1'b0, r_f};
        case (r_o)
            3'd1:    w_dsr_prep = {2'b00, r_f[31:1]};
            3'd3:    w_dsr_prep = {r_f, 1'b0};
            default: w_dsr_prep = {1'b0, r_f};
        endcase
    end

`ifdef ROUND_DIV_EN
    assign w_dvd_prep = c_CLK + DVD_W'(w_dsr_prep >> 1);
`else
    assign w_dvd_prep = c_CLK;
`endif

    // Restoring step: the remainder stays below the divisor, so one extra bit
    // is enough to hold the shifted value before the compare.
    assign w_rem_sh = {r_rem, r_dvd[r_cnt]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dsr});

    always_comb begin
        w_res = r_quo[OUT_W-1:0];
        if (r_f == c_SILENCE) begin
            w_res = {{(OUT_W-1){1'b0}}, 1'b1};
        end else if (r_dsr == '0 || (|r_quo[DVD_W-1:OUT_W])) begin
            w_res = c_MAX;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_PREP;
            S_PREP:  w_next = S_DIV;
            S_DIV:   if (r_cnt == 5'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_f      <= '0;
            r_o      <= '0;
            r_primed <= 1'b0;
            r_dsr    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            note_div <= {{(OUT_W-1){1'b0}}, 1'b1};
            done     <= 1'b0;
        end else begin
            r_state <= w_next;
            done    <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_f      <= freq_in;
                        r_o      <= octave;
                        r_primed <= 1'b1;
                    end
                end
                S_PREP: begin
                    r_dsr <= w_dsr_prep;
                    r_dvd <= w_dvd_prep;
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= 5'd27;
                end
                S_DIV: begin
                    r_rem        <= w_ge ? DSR_W'(w_rem_sh - {1'b0, r_dsr}) : DSR_W'(w_rem_sh);
                    r_quo[r_cnt] <= w_ge;
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                end
                S_DONE: begin
                    note_div <= w_res;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_note_div_calc.sv
// ============================================================================
// Module   : tb_note_div_calc
// Purpose  : Self-checking bench for note_div_calc against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_note_div_calc;

    localparam longint CLK_HZ  = 100_000_000;
    localparam longint SIL     = 100_000_000;
    localparam longint MAXV    = (1 << 22) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] freq_in;
    logic [2:0]  octave;
    logic [21:0] note_div;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    note_div_calc dut (
        .clk      (clk),
        .rst      (rst),
        .freq_in  (freq_in),
        .octave   (octave),
        .note_div (note_div),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] model(input longint f, input int o);
        longint d, dvd, q;
        logic [63:0] qv;
        if (f == SIL) return 22'd1;
        d = (o == 1) ? (f / 2) : (o == 3) ? (f * 2) : f;
        if (d == 0) return MAXV[21:0];
`ifdef ROUND_DIV_EN
        dvd = (CLK_HZ + d / 2) % (longint'(1) << 28);
`else
        dvd = CLK_HZ;
`endif
        q = dvd / d;
        if (q > MAXV) return MAXV[21:0];
        qv = 64'(q);
        return qv[21:0];
    endfunction

    // Waits for the done pulse; lat counts edges from the one that samples the change.
    task automatic wait_done(output int lat, output int bcnt, output logic [21:0] pre);
        lat = 0; bcnt = 0; pre = note_div;
        while (lat < 100) begin
            pre = note_div;
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        int lat, bcnt; logic [21:0] pre, exp;
        rst = 1'b1; freq_in = 32'd440; octave = 3'd2;
        repeat (2) begin
            @(posedge clk); #1;
            n_cmp++;
            if (note_div !== 22'd1 || busy !== 1'b0 || done !== 1'b0) begin
                n_bad++; $display("FAIL reset_state: note_div=%0d busy=%b done=%b required 1/0/0", note_div, busy, done);
            end
        end
        rst = 1'b0;
        exp = model(440, 2);
        wait_done(lat, bcnt, pre);
        n_cmp++;
        if (lat !== 31 || bcnt !== 30) begin
            n_bad++; $display("FAIL first_latency: lat=%0d busy_cycles=%0d required 31/30", lat, bcnt);
        end
        n_cmp++;
        if (note_div !== exp || pre !== 22'd1) begin
            n_bad++; $display("FAIL first_value: note_div=%0d pre=%0d required %0d/1", note_div, pre, exp);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL done_pulse_width: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_steady;
        int dcnt = 0, bcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        n_cmp++;
        if (dcnt !== 0 || bcnt !== 0) begin
            n_bad++; $display("FAIL steady_input: done_pulses=%0d busy_cycles=%0d required 0/0", dcnt, bcnt);
        end
    endtask

    task automatic test_octave;
        int lat, bcnt; logic [21:0] pre, old, exp;
        for (int o = 1; o <= 3; o += 2) begin
            old = note_div;
            freq_in = 32'd440; octave = 3'(o);
            exp = model(440, o);
            wait_done(lat, bcnt, pre);
            n_cmp++;
            if (lat !== 31 || note_div !== exp || pre !== old) begin
                n_bad++; $display("FAIL octave_%0d: lat=%0d note_div=%0d pre=%0d required 31/%0d/%0d", o, lat, note_div, pre, exp, old);
            end
        end
    endtask

    task automatic test_silence;
        int lat, bcnt; logic [21:0] pre;
        for (int o = 0; o < 8; o++) begin
            freq_in = 32'(SIL); octave = 3'(o);
            wait_done(lat, bcnt, pre);
            n_cmp++;
            if (lat !== 31 || note_div !== 22'd1) begin
                n_bad++; $display("FAIL silence_oct%0d: lat=%0d note_div=%0d required 31/1", o, lat, note_div);
            end
        end
    endtask

    task automatic test_boundary;
        int lat, bcnt; logic [21:0] pre, exp;
        longint f_tab [3] = '{0, 20, 48};
        int     o_tab [3] = '{2, 2, 1};
        for (int i = 0; i < 3; i++) begin
            freq_in = 32'(f_tab[i]); octave = 3'(o_tab[i]);
            exp = model(f_tab[i], o_tab[i]);
            wait_done(lat, bcnt, pre);
            n_cmp++;
            if (lat !== 31 || note_div !== exp) begin
                n_bad++; $display("FAIL boundary_f%0d_o%0d: lat=%0d note_div=%0d required 31/%0d", f_tab[i], o_tab[i], lat, note_div, exp);
            end
        end
    endtask

    task automatic test_random;
        int lat, bcnt; logic [21:0] pre, exp;
        longint f; int o;
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       f = longint'($urandom_range(1, 200));
                1:       f = longint'($urandom_range(20, 20000));
                default: f = longint'($urandom);
            endcase
            o = int'($urandom_range(0, 7));
            if (32'(f) == freq_in && 3'(o) == octave) o = (o + 1) % 8;
            freq_in = 32'(f); octave = 3'(o);
            exp = model(f, o);
            wait_done(lat, bcnt, pre);
            n_cmp++;
            if (lat !== 31 || note_div !== exp) begin
                n_bad++; $display("FAIL random_f%0d_o%0d: lat=%0d note_div=%0d required 31/%0d", f, o, lat, note_div, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [21:0] old, e1, e2;
        logic [21:0] vals [2];
        int ndone = 0, nstray = 0;
        old = note_div;
        e1 = model(440, 2);
        e2 = model(262, 2);
        freq_in = 32'd440; octave = 3'd2;
        repeat (12) @(posedge clk);
        #1;
        freq_in = 32'd262;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (ndone < 2) vals[ndone] = note_div;
                ndone++;
            end
            if (note_div !== old && note_div !== e1 && note_div !== e2) nstray++;
        end
        n_cmp++;
        if (ndone !== 2 || nstray !== 0) begin
            n_bad++; $display("FAIL b2b_pulses: done_pulses=%0d stray_values=%0d required 2/0", ndone, nstray);
        end
        n_cmp++;
        if (ndone >= 2 && (vals[0] !== e1 || vals[1] !== e2)) begin
            n_bad++; $display("FAIL b2b_values: first=%0d second=%0d required %0d/%0d", vals[0], vals[1], e1, e2);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt; logic [21:0] pre, exp;
        freq_in = 32'd1000; octave = 3'd2;
        exp = model(1000, 2);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (note_div !== 22'd1 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_state: note_div=%0d busy=%b done=%b required 1/0/0", note_div, busy, done);
        end
        rst = 1'b0;
        wait_done(lat, bcnt, pre);
        n_cmp++;
        if (lat !== 31 || note_div !== exp || pre !== 22'd1) begin
            n_bad++; $display("FAIL mid_reset_recompute: lat=%0d note_div=%0d pre=%0d required 31/%0d/1", lat, note_div, pre, exp);
        end
    endtask

    initial begin
        test_reset;
        test_steady;
        test_octave;
        test_silence;
        test_boundary;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_steady;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
